// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one start/done GCD engine among N_REQ requesters.
// Optional WAIT timeout with engine abort is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [W-1:0]       rsp_data,
   output logic               rsp_err,
   input  logic               rsp_ready,
   output logic               eng_start,
   output logic [W-1:0]       eng_a,
   output logic [W-1:0]       eng_b,
   input  logic               eng_done,
   input  logic [W-1:0]       eng_result,
   output logic               eng_abort,
   output logic               busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("gcd_arbiter: N_REQ must be within 2..8");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("gcd_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, id_q, id_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;

   logic [IW-1:0]    win_idx, cand;
   logic             win_found;
   logic [N_REQ-1:0] win_oh;
   logic [W-1:0]     sel_a, sel_b;
   logic             bypass;

`ifdef GCD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d, abort_q, abort_d;
   logic          tmo_hit;

   assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

   // Search starts one past the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = ptr_q;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + IW'(1);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      win_oh = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (IW'(i) == win_idx) begin
            sel_a     = req_a[i*W +: W];
            sel_b     = req_b[i*W +: W];
            win_oh[i] = win_found;
         end
      end
   end

   assign req_ready = (state_q == S_IDLE) ? win_oh : '0;
   assign bypass    = (sel_a == '0) || (sel_b == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (win_found) state_d = bypass ? S_RESP : S_LAUNCH;
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (eng_done) state_d = S_RESP;
`ifdef GCD_ARB_TIMEOUT_EN
            else if (tmo_hit) state_d = S_RESP;
`endif
         end
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // A zero operand would never terminate the subtractive engine; gcd(0,x)=x is answered directly.
   always_comb begin
      ptr_d = ptr_q;
      id_d  = id_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
      abort_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               ptr_d = win_idx;
               id_d  = win_idx;
               a_d   = sel_a;
               b_d   = sel_b;
               if (bypass) res_d = sel_a | sel_b;
`ifdef GCD_ARB_TIMEOUT_EN
               err_d = 1'b0;
`endif
            end
         end
         S_LAUNCH: begin
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_WAIT: begin
            if (eng_done) begin
               res_d = eng_result;
            end
`ifdef GCD_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               res_d   = '0;
               err_d   = 1'b1;
               abort_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= IW'(N_REQ - 1);
         id_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
`endif
      end else begin
         ptr_q <= ptr_d;
         id_q  <= id_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
`ifdef GCD_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         abort_q <= abort_d;
`endif
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      eng_start = (state_q == S_LAUNCH);
      eng_a     = a_q;
      eng_b     = b_q;
      rsp_data  = res_q;
      rsp_valid = '0;
      if (state_q == S_RESP) rsp_valid[id_q] = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
      rsp_err   = err_q;
      eng_abort = abort_q;
`else
      rsp_err   = 1'b0;
      eng_abort = 1'b0;
`endif
   end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural engine, Euclid reference and round-robin model.
module tb_gcd_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TMO = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready, rsp_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   rsp_data, eng_a, eng_b, eng_res_m, eng_result;
   logic           rsp_err, rsp_ready, eng_start, eng_done_m, spur_done, eng_done;
   logic           eng_abort, busy;

   int total = 0, bad = 0;
   int m_ptr = N - 1;
   int eng_delay = 3, eng_cnt = -1, n_starts = 0, done_edge = 0, cyc = 0;
   bit eng_hang = 1'b0;
   logic [W-1:0] eng_val;

   assign eng_done   = eng_done_m | spur_done;
   assign eng_result = spur_done ? 16'hDEAD : eng_res_m;

   gcd_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
      .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned x = a, y = b, t;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      return W'(x);
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      logic [N-1:0] s;
      for (int off = 1; off <= N; off++) begin
         s = v >> ((ptr + off) % N);
         if (s[0]) return (ptr + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // Engine: answers gcd(eng_a, eng_b) eng_delay cycles after start, or never when hung.
   initial begin
      eng_done_m = 1'b0;
      eng_res_m  = '0;
      forever begin
         @(negedge clk);
         eng_done_m = 1'b0;
         if (eng_cnt > 0) eng_cnt--;
         else if (eng_cnt == 0) begin
            eng_done_m = 1'b1; eng_res_m = eng_val; eng_cnt = -1; done_edge = cyc + 1;
         end
         if (eng_start === 1'b1) begin
            n_starts++;
            eng_val = gcd_ref(eng_a, eng_b);
            eng_cnt = eng_hang ? -1 : eng_delay - 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic test_reset;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; spur_done = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({busy, eng_start, eng_abort, rsp_err, rsp_valid} !== '0) begin bad++;
         $display("FAIL reset_ctrl: got %b want 0", {busy, eng_start, eng_abort, rsp_err, rsp_valid}); end
      total++; if ({eng_a, eng_b, rsp_data} !== '0) begin bad++;
         $display("FAIL reset_data: got %h want 0", {eng_a, eng_b, rsp_data}); end
      total++; if (req_ready !== '0) begin bad++;
         $display("FAIL reset_ready: got %b want 0", req_ready); end
      rst_n = 1'b1; m_ptr = N - 1;
      @(negedge clk);
      req_valid = '1; #1;
      total++; if (req_ready !== oh(rr_pick(req_valid, m_ptr))) begin bad++;
         $display("FAIL reset_first_grant: got %b want %b", req_ready, oh(rr_pick(req_valid, m_ptr))); end
      req_valid = '0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++;
         $display("FAIL dropped_valid: busy got %b want 0", busy); end
   endtask

   task automatic test_single;
      int c = 0;
      eng_delay = 5;
      set_req(0, 16'd48, 16'd18); req_valid = 4'b0001; #1;
      total++; if (req_ready !== 4'b0001) begin bad++;
         $display("FAIL single_grant: got %b want 0001", req_ready); end
      @(negedge clk);
      req_valid = '0; m_ptr = 0;
      total++; if ({eng_start, eng_a, eng_b, req_ready} !== {1'b1, 16'd48, 16'd18, 4'b0}) begin bad++;
         $display("FAIL single_launch: got %b/%0d/%0d/%b want 1/48/18/0000", eng_start, eng_a, eng_b, req_ready); end
      @(negedge clk);
      total++; if (eng_start !== 1'b0) begin bad++;
         $display("FAIL single_start_pulse: got %b want 0", eng_start); end
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      total++; if ({rsp_valid, rsp_data, rsp_err} !== {4'b0001, 16'd6, 1'b0}) begin bad++;
         $display("FAIL single_rsp: got %b/%0d/%b want 0001/6/0", rsp_valid, rsp_data, rsp_err); end
      total++; if (cyc !== done_edge) begin bad++;
         $display("FAIL single_latency: rsp after edge %0d want edge %0d", cyc, done_edge); end
      rsp_ready = 1'b1;
      @(negedge clk);
      total++; if ({rsp_valid, busy} !== '0) begin bad++;
         $display("FAIL single_release: got %b/%b want 0/0", rsp_valid, busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin;
      logic [W-1:0] ea[N], eb[N];
      logic [W-1:0] g;
      int exp_id, c;
      for (int i = 0; i < N; i++) begin
         g = W'($urandom_range(1, 20));
         ea[i] = g * W'($urandom_range(1, 50)); eb[i] = g * W'($urandom_range(1, 50));
         set_req(i, ea[i], eb[i]);
      end
      rsp_ready = 1'b1; req_valid = '1;
      for (int t = 0; t < 8; t++) begin
         eng_delay = $urandom_range(1, 6);
         #1;
         exp_id = rr_pick(req_valid, m_ptr);
         total++; if (req_ready !== oh(exp_id)) begin bad++;
            $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, oh(exp_id)); end
         @(negedge clk);
         m_ptr = exp_id;
         total++; if ({req_ready, eng_start} !== {4'b0, 1'b1}) begin bad++;
            $display("FAIL rr_launch%0d: ready %b start %b want 0000/1", t, req_ready, eng_start); end
         g = gcd_ref(ea[exp_id], eb[exp_id]);
         ea[exp_id] = W'($urandom_range(1, 900)); eb[exp_id] = W'($urandom_range(1, 900));
         set_req(exp_id, ea[exp_id], eb[exp_id]);
         c = 0;
         while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
         total++; if ({rsp_valid, rsp_data} !== {oh(exp_id), g}) begin bad++;
            $display("FAIL rr_rsp%0d: got %b/%0d want %b/%0d", t, rsp_valid, rsp_data, oh(exp_id), g); end
         @(negedge clk);
      end
      req_valid = '0; rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_bypass;
      int n0 = n_starts;
      logic [W-1:0] a, b;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin a = 16'd0; b = 16'd35; end
            1: begin a = 16'd0; b = 16'd0; end
            2: begin a = W'($urandom_range(1, 60000)); b = 16'd0; end
            default: begin a = 16'd0; b = W'($urandom_range(1, 60000)); end
         endcase
         set_req(2, a, b); req_valid = 4'b0100; #1;
         total++; if (req_ready !== 4'b0100) begin bad++;
            $display("FAIL zero_grant%0d: got %b want 0100", k, req_ready); end
         @(negedge clk);
         m_ptr = 2;
         total++; if ({rsp_valid, rsp_data, eng_start} !== {4'b0100, a | b, 1'b0}) begin bad++;
            $display("FAIL zero_rsp%0d: got %b/%0d/%b want 0100/%0d/0", k, rsp_valid, rsp_data, eng_start, a | b); end
         @(negedge clk);
      end
      req_valid = '0; rsp_ready = 1'b0;
      @(negedge clk);
      total++; if (n_starts !== n0) begin bad++;
         $display("FAIL zero_no_start: starts got %0d want %0d", n_starts, n0); end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] g, a, b;
      int c = 0;
      a = W'($urandom_range(1, 3000)); b = W'($urandom_range(1, 3000)); g = gcd_ref(a, b);
      eng_delay = 2; rsp_ready = 1'b0;
      set_req(1, a, b); req_valid = 4'b0010;
      @(negedge clk);
      m_ptr = 1; req_valid = '1;
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      for (int j = 0; j < 10; j++) begin
         total++; if ({rsp_valid, rsp_data, req_ready, eng_abort, rsp_err} !== {4'b0010, g, 4'b0, 2'b0}) begin bad++;
            $display("FAIL hold%0d: got %b/%0d/%b want 0010/%0d/0000", j, rsp_valid, rsp_data, req_ready, g); end
         @(negedge clk);
         spur_done = (j == 3);
      end
      spur_done = 1'b0;
      total++; if ({rsp_valid, rsp_data} !== {4'b0010, g}) begin bad++;
         $display("FAIL hold_final: got %b/%0d want 0010/%0d", rsp_valid, rsp_data, g); end
      rsp_ready = 1'b1; req_valid = '0;
      @(negedge clk);
      total++; if ({rsp_valid, busy} !== '0) begin bad++;
         $display("FAIL hold_release: got %b/%b want 0/0", rsp_valid, busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] a, b;
      int c = 0;
      eng_delay = 20;
      set_req(3, 16'd91, 16'd39); req_valid = 4'b1000;
      @(negedge clk);
      m_ptr = 3; req_valid = '0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++;
         $display("FAIL midrst_busy: got %b want 1", busy); end
      rst_n = 1'b0; #1;
      m_ptr = N - 1;
      total++; if ({busy, rsp_valid, eng_start, eng_a, eng_b} !== '0) begin bad++;
         $display("FAIL midrst_async: got %b/%b/%0d/%0d want 0", busy, rsp_valid, eng_a, eng_b); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      while (eng_cnt != -1 && c < 40) begin @(negedge clk); c++; end
      @(negedge clk); @(negedge clk);
      total++; if ({busy, rsp_valid, c < 40} !== {1'b0, 4'b0, 1'b1}) begin bad++;
         $display("FAIL midrst_stale: busy %b rsp %b waited %0d want 0/0000/<40", busy, rsp_valid, c); end
      a = W'($urandom_range(1, 5000)); b = W'($urandom_range(1, 5000));
      for (int i = 0; i < N; i++) set_req(i, a, b);
      eng_delay = 2; rsp_ready = 1'b1; req_valid = '1; #1;
      total++; if (req_ready !== oh(rr_pick(req_valid, m_ptr))) begin bad++;
         $display("FAIL midrst_grant: got %b want %b", req_ready, oh(rr_pick(req_valid, m_ptr))); end
      @(negedge clk);
      req_valid = '0; m_ptr = 0; c = 0;
      while (rsp_valid === '0 && c < 60) begin @(negedge clk); c++; end
      total++; if ({rsp_valid, rsp_data} !== {4'b0001, gcd_ref(a, b)}) begin bad++;
         $display("FAIL midrst_rsp: got %b/%0d want 0001/%0d", rsp_valid, rsp_data, gcd_ref(a, b)); end
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

`ifdef GCD_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int c = 0;
      eng_hang = 1'b1; rsp_ready = 1'b0;
      set_req(0, 16'd77, 16'd21); req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0; m_ptr = 0;
      while (eng_abort !== 1'b1 && c < 40) begin @(negedge clk); c++; end
      total++; if (c !== TMO + 1) begin bad++;
         $display("FAIL tmo_latency: abort after %0d cycles want %0d", c, TMO + 1); end
      total++; if ({rsp_valid, rsp_err, rsp_data} !== {4'b0001, 1'b1, 16'd0}) begin bad++;
         $display("FAIL tmo_rsp: got %b/%b/%0d want 0001/1/0", rsp_valid, rsp_err, rsp_data); end
      @(negedge clk);
      total++; if ({eng_abort, rsp_valid} !== {1'b0, 4'b0001}) begin bad++;
         $display("FAIL tmo_pulse: abort %b rsp %b want 0/0001", eng_abort, rsp_valid); end
      rsp_ready = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++;
         $display("FAIL tmo_release: busy got %b want 0", busy); end
      rsp_ready = 1'b0; eng_hang = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_bypass();
      test_backpressure();
      test_reset_mid();
`ifdef GCD_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
